ct_event_monitor: RTL and testbench

Sequential qualifier and event counter sitting directly downstream of the CT code decoder; it consumes the decoder's two match outputs, CT1 (C0'.C1.K0.K1') and CT2 (C0.C1'.K0.K1). A match counts as an event only if it stays stable for a programmable number of clock cycles. For each qualified event the block emits a one-cycle pulse, keeps a saturating count per code, raises a sticky alarm on a run of consecutive CT2 events, and flags the illegal case of both matches asserted together.

---
 rtl/ct_mon_pkg.sv | 22 ++
 rtl/ct_event_monitor_sat_counter.sv | 34 +++
 rtl/ct_event_monitor.sv | 152 +++++++++++++++
 tb/tb_ct_event_monitor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_mon_pkg.sv
// Shared types for the CT event monitor: FSM state encoding and the
// classification of the decoder's two match lines on each sampled edge.
package ct_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL1 = 2'd1,
    QUAL2 = 2'd2,
    HOLD  = 2'd3
  } mon_state_e;

  // Input class encoding is {ct2, ct1}, so a class is just the raw pair.
  localparam logic [1:0] CLS_NONE  = 2'b00;
  localparam logic [1:0] CLS_SOLO1 = 2'b01;
  localparam logic [1:0] CLS_SOLO2 = 2'b10;
  localparam logic [1:0] CLS_BOTH  = 2'b11;

  function automatic logic [1:0] classify(input logic ct1, input logic ct2);
    return {ct2, ct1};
  endfunction

endpackage

// File: rtl/ct_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ct_event_monitor.sv
// Qualifies CT1/CT2 decoder matches over QUAL_CYC stable samples, emits one
// pulse per qualified event, counts events and tracks a CT2 streak alarm.
module ct_event_monitor
  import ct_mon_pkg::*;
#(
  parameter int QUAL_CYC  = 3,
  parameter int CNT_W     = 8,
  parameter int ALARM_THR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ct1,
  input  logic             ct2,
  input  logic             en,
  input  logic             clr,
  output logic             ct1_evt,
  output logic             ct2_evt,
  output logic [CNT_W-1:0] ct1_cnt,
  output logic [CNT_W-1:0] ct2_cnt,
  output logic             alarm,
  output logic             err,
  output logic             busy
);

  localparam int QW = $clog2(QUAL_CYC + 1);
  localparam int SW = $clog2(ALARM_THR + 1);
  localparam logic [QW-1:0] QUAL_Q = QW'(QUAL_CYC);
  localparam logic [SW-1:0] THR_S  = SW'(ALARM_THR);

  mon_state_e    state_q, state_d;
  logic [QW-1:0] qual_q, qual_d;
  logic [QW-1:0] run1, run2;
  logic [SW-1:0] streak_q, streak_d;
  logic          alarm_q, alarm_d;
  logic          err_q, err_d;
  logic [1:0]    evt_q, evt_d;
  logic [1:0]    cls;
  logic [CNT_W-1:0] cnt [2];

  assign cls = classify(ct1, ct2);

  // Length of the current solo run if this sample extends it (1 otherwise).
  assign run1 = (state_q == QUAL1) ? qual_q + QW'(1) : QW'(1);
  assign run2 = (state_q == QUAL2) ? qual_q + QW'(1) : QW'(1);

  always_comb begin
    state_d  = state_q;
    qual_d   = qual_q;
    evt_d    = 2'b00;
    err_d    = err_q;
    streak_d = streak_q;
    alarm_d  = alarm_q;

    if (clr) begin
      state_d  = IDLE;
      qual_d   = '0;
      err_d    = 1'b0;
      streak_d = '0;
      alarm_d  = 1'b0;
    end else if (!en) begin
      state_d = IDLE;
      qual_d  = '0;
    end else begin
      if (cls == CLS_BOTH) begin
        err_d = 1'b1;
      end

      if (state_q == HOLD) begin
        // A held match keeps us here; only a quiet sample re-arms.
        if (cls == CLS_NONE) begin
          state_d = IDLE;
        end
      end else begin
        case (cls)
          CLS_SOLO1: begin
            if (run1 == QUAL_Q) begin
              evt_d[0] = 1'b1;
              state_d  = HOLD;
              qual_d   = '0;
            end else begin
              state_d = QUAL1;
              qual_d  = run1;
            end
          end
          CLS_SOLO2: begin
            if (run2 == QUAL_Q) begin
              evt_d[1] = 1'b1;
              state_d  = HOLD;
              qual_d   = '0;
            end else begin
              state_d = QUAL2;
              qual_d  = run2;
            end
          end
          default: begin
            state_d = IDLE;
            qual_d  = '0;
          end
        endcase
      end

      if (evt_d[0]) begin
        streak_d = '0;
      end else if (evt_d[1]) begin
        if (streak_q != THR_S) begin
          streak_d = streak_q + SW'(1);
        end
        if (streak_d == THR_S) begin
          alarm_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      qual_q   <= '0;
      streak_q <= '0;
      alarm_q  <= 1'b0;
      err_q    <= 1'b0;
      evt_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      qual_q   <= qual_d;
      streak_q <= streak_d;
      alarm_q  <= alarm_d;
      err_q    <= err_d;
      evt_q    <= evt_d;
    end
  end

  // Index 0 counts CT1 events, index 1 counts CT2 events.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (evt_d[gi]),
      .clr   (clr),
      .count (cnt[gi])
    );
  end

  assign ct1_evt = evt_q[0];
  assign ct2_evt = evt_q[1];
  assign ct1_cnt = cnt[0];
  assign ct2_cnt = cnt[1];
  assign alarm   = alarm_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ct_event_monitor.sv
// Directed plan scenarios plus randomized segments for ct_event_monitor,
// checked every cycle against a run-length based reference model.
module tb_ct_event_monitor;

  localparam int Q   = 3;
  localparam int THR = 4;

  logic clk = 1'b0;
  logic rst_n, ct1, ct2, en, clr;
  logic       a_e1, a_e2, a_alarm, a_err, a_busy;
  logic [7:0] a_c1, a_c2;
  logic       b_e1, b_e2, b_alarm, b_err, b_busy;
  logic [1:0] b_c1, b_c2;

  always #5 clk = ~clk;

  ct_event_monitor #(.QUAL_CYC(Q), .CNT_W(8), .ALARM_THR(THR)) dut_a (
    .clk(clk), .rst_n(rst_n), .ct1(ct1), .ct2(ct2), .en(en), .clr(clr),
    .ct1_evt(a_e1), .ct2_evt(a_e2), .ct1_cnt(a_c1), .ct2_cnt(a_c2),
    .alarm(a_alarm), .err(a_err), .busy(a_busy)
  );

  ct_event_monitor #(.QUAL_CYC(Q), .CNT_W(2), .ALARM_THR(THR)) dut_b (
    .clk(clk), .rst_n(rst_n), .ct1(ct1), .ct2(ct2), .en(en), .clr(clr),
    .ct1_evt(b_e1), .ct2_evt(b_e2), .ct1_cnt(b_c1), .ct2_cnt(b_c2),
    .alarm(b_alarm), .err(b_err), .busy(b_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks how long the current solo code has been seen,
  // whether an event is being held off until a quiet sample, and totals.
  int m_run, m_code, m_c1, m_c2, m_streak;
  bit m_hold, m_alarm, m_err, m_e1, m_e2;

  function automatic void model_reset();
    m_run = 0; m_code = 0; m_c1 = 0; m_c2 = 0; m_streak = 0;
    m_hold = 0; m_alarm = 0; m_err = 0; m_e1 = 0; m_e2 = 0;
  endfunction

  function automatic void model_step(input bit c1, input bit c2, input bit e, input bit cl);
    int code;
    m_e1 = 0;
    m_e2 = 0;
    if (cl) begin
      m_run = 0; m_hold = 0; m_c1 = 0; m_c2 = 0;
      m_streak = 0; m_alarm = 0; m_err = 0;
      return;
    end
    if (!e) begin
      m_run = 0;
      m_hold = 0;
      return;
    end
    if (c1 && c2) m_err = 1;
    if (m_hold) begin
      if (!c1 && !c2) m_hold = 0;
    end else if (c1 ^ c2) begin
      code   = c1 ? 1 : 2;
      m_run  = (m_run > 0 && m_code == code) ? m_run + 1 : 1;
      m_code = code;
      if (m_run == Q) begin
        m_run  = 0;
        m_hold = 1;
        if (code == 1) begin
          m_e1 = 1; m_c1++; m_streak = 0;
        end else begin
          m_e2 = 1; m_c2++; m_streak++;
          if (m_streak >= THR) m_alarm = 1;
        end
      end
    end else begin
      m_run = 0;
    end
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic compare_all();
    bit busy_exp;
    busy_exp = m_hold || (m_run > 0);
    check_eq("a_ct1_evt", int'(a_e1), int'(m_e1));
    check_eq("a_ct2_evt", int'(a_e2), int'(m_e2));
    check_eq("a_ct1_cnt", int'(a_c1), sat(m_c1, 255));
    check_eq("a_ct2_cnt", int'(a_c2), sat(m_c2, 255));
    check_eq("a_alarm",   int'(a_alarm), int'(m_alarm));
    check_eq("a_err",     int'(a_err), int'(m_err));
    check_eq("a_busy",    int'(a_busy), int'(busy_exp));
    check_eq("b_ct1_cnt", int'(b_c1), sat(m_c1, 3));
    check_eq("b_ct2_cnt", int'(b_c2), sat(m_c2, 3));
    check_eq("b_ct1_evt", int'(b_e1), int'(m_e1));
    check_eq("b_ct2_evt", int'(b_e2), int'(m_e2));
    check_eq("b_alarm",   int'(b_alarm), int'(m_alarm));
    check_eq("b_err",     int'(b_err), int'(m_err));
    check_eq("b_busy",    int'(b_busy), int'(busy_exp));
  endtask

  task automatic step(input bit c1, input bit c2, input bit e, input bit cl);
    @(negedge clk);
    ct1 = c1; ct2 = c2; en = e; clr = cl;
    @(posedge clk);
    model_step(c1, c2, e, cl);
    #1;
    compare_all();
  endtask

  task automatic run_code(input int code, input int len);
    for (int i = 0; i < len; i++) step(code == 1, code == 2, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ct1_evt"}, int'(a_e1), 0);
    check_eq({tag, "_ct2_evt"}, int'(a_e2), 0);
    check_eq({tag, "_ct1_cnt"}, int'(a_c1), 0);
    check_eq({tag, "_ct2_cnt"}, int'(a_c2), 0);
    check_eq({tag, "_alarm"},   int'(a_alarm), 0);
    check_eq({tag, "_err"},     int'(a_err), 0);
    check_eq({tag, "_busy"},    int'(a_busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; ct1 = 1'b0; ct2 = 1'b0; en = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset released");

    // ct1 held 13 cycles: one event on the 3rd edge, busy until release.
    step(1, 0, 1, 0);
    check_eq("busy_first_edge", int'(a_busy), 1);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    check_eq("ct1_evt_at_q", int'(a_e1), 1);
    step(1, 0, 1, 0);
    check_eq("ct1_evt_one_cycle", int'(a_e1), 0);
    run_code(1, 9);
    check_eq("ct1_cnt_held", int'(a_c1), 1);
    step(0, 0, 1, 0);
    check_eq("busy_after_release", int'(a_busy), 0);
    $display("txn ct1 held: cnt=%0d", a_c1);

    // ct2 for only 2 cycles: no event.
    run_code(2, 2);
    step(0, 0, 1, 0);
    check_eq("ct2_short_cnt", int'(a_c2), 0);
    check_eq("ct2_short_idle", int'(a_busy), 0);
    $display("txn ct2 short pulse: cnt=%0d", a_c2);

    // Four CT2 events: alarm rises together with the 4th pulse.
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      run_code(2, Q);
      check_eq("alarm_vs_streak", int'(a_alarm), (k == 3) ? 1 : 0);
      step(0, 0, 1, 0);
    end
    $display("txn ct2 streak: alarm=%0d", a_alarm);

    // CT1 event before the 4th CT2 event breaks the streak.
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        run_code(1, Q);
        step(0, 0, 1, 0);
      end
      run_code(2, Q);
      step(0, 0, 1, 0);
    end
    check_eq("alarm_broken", int'(a_alarm), 0);
    $display("txn broken streak: alarm=%0d", a_alarm);

    // Both matches together: err only, then clr wipes it.
    step(1, 1, 1, 0);
    check_eq("both_err", int'(a_err), 1);
    check_eq("both_no_evt", int'(a_e1) + int'(a_e2), 0);
    step(0, 0, 1, 1);
    check_eq("clr_err", int'(a_err), 0);
    check_eq("clr_cnt", int'(a_c1) + int'(a_c2), 0);
    $display("txn both/clr: err=%0d", a_err);

    // Five CT1 events: the 2-bit counter sticks at 3.
    for (int k = 0; k < 5; k++) begin
      run_code(1, Q);
      step(0, 0, 1, 0);
    end
    check_eq("b_ct1_sat", int'(b_c1), 3);
    check_eq("a_ct1_5", int'(a_c1), 5);
    $display("txn saturation: a=%0d b=%0d", a_c1, b_c1);

    // Asynchronous reset in the middle of qualification.
    run_code(1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(negedge clk);
    ct1 = 1'b0; ct2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    check_eq("post_rst_no_early_evt", int'(a_e1), 0);
    step(1, 0, 1, 0);
    check_eq("post_rst_evt", int'(a_e1), 1);
    step(0, 0, 1, 0);
    $display("txn async reset: cnt=%0d", a_c1);

    // Randomized segments of solo / both / none runs with occasional en=0 and clr.
    for (int s = 0; s < 400; s++) begin
      int  pick, len;
      bit  e, cl;
      pick = int'($urandom_range(0, 19));
      len  = int'($urandom_range(1, 6));
      e    = ($urandom_range(0, 15) != 0);
      cl   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < len; i++) begin
        if (pick < 8)       step(1, 0, e, cl && (i == 0));
        else if (pick < 16) step(0, 1, e, cl && (i == 0));
        else if (pick < 17) step(1, 1, e, cl && (i == 0));
        else                step(0, 0, e, cl && (i == 0));
      end
      $display("txn rnd %0d: class=%0d len=%0d en=%0d clr=%0d c1=%0d c2=%0d alarm=%0d",
               s, pick, len, e, cl, a_c1, a_c2, a_alarm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
